// File: rtl/button_matrix_scanner_if.sv
// Bus between the button matrix scanner and its surroundings: matrix drive/sense,
// debounced key map and the press-event stream.
interface button_matrix_scanner_if #(
    parameter int N = 5
);
    localparam int IW = $clog2(N*N);

    logic            ena;
    logic [N-1:0]    scan_cols;
    logic [N-1:0]    sense_rows;
    logic [N*N-1:0]  pressed;
    logic            event_valid;
    logic            event_ready;
    logic [IW-1:0]   event_index;
    logic            overflow;

    modport master (
        input  ena, sense_rows, event_ready,
        output scan_cols, pressed, event_valid, event_index, overflow
    );

    modport slave (
        output ena, sense_rows, event_ready,
        input  scan_cols, pressed, event_valid, event_index, overflow
    );
endinterface

// File: rtl/button_matrix_scanner.sv
// Column-scanned N x N push-button matrix with per-key debounce and a FIFO of
// press events (cell index N*row + col) for the grid edit logic.
module button_matrix_scanner #(
    parameter int N              = 5,
    parameter int SETTLE_DIVIDER = 12,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    button_matrix_scanner_if.master  bus
);
    localparam int IW = $clog2(N*N);
    localparam int CW = $clog2(N);
    localparam int DW = $clog2(DEBOUNCE_SCANS) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_SETTLE  = 2'd0;
    localparam logic [1:0] ST_SAMPLE  = 2'd1;
    localparam logic [1:0] ST_ADVANCE = 2'd2;

    logic [1:0]                state;
    logic [SETTLE_DIVIDER:0]   settle_cnt;
    logic [CW-1:0]             col, row;
    logic [N-1:0]              cols_q;
    logic [N-1:0]              sync1, sync2;
    logic [N*N-1:0]            pressed_q;
    logic [N*N-1:0][DW-1:0]    dcnt;

    logic [IW-1:0]             key_idx;
    logic                      sample_bit, cur, toggle, push, pop, do_push, drop;
    logic [DW-1:0]             cur_cnt, cnt_inc;

    logic [IW-1:0]             mem [FIFO_DEPTH];
    logic [AW:0]               wr_ptr, rd_ptr;
    logic                      empty, full, ovf_q;

    // Row sense lines are asynchronous to the scan clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.sense_rows;
            sync2 <= sync1;
        end
    end

    assign key_idx    = IW'(N) * IW'(row) + IW'(col);
    assign sample_bit = sync2[row];
    assign cur        = pressed_q[key_idx];
    assign cur_cnt    = dcnt[key_idx];
    assign cnt_inc    = cur_cnt + 1'b1;
    assign toggle     = bus.ena && (state == ST_SAMPLE) && (sample_bit != cur)
                        && (cnt_inc == DW'(DEBOUNCE_SCANS));
    assign push       = toggle && !cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            col        <= '0;
            row        <= '0;
            cols_q     <= N'(1);
            pressed_q  <= '0;
            dcnt       <= '0;
        end else if (bus.ena) begin
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt[SETTLE_DIVIDER]) begin
                        settle_cnt <= '0;
                        row        <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    // A sample agreeing with the current state restarts the debounce.
                    if (sample_bit == cur) begin
                        dcnt[key_idx] <= '0;
                    end else if (toggle) begin
                        dcnt[key_idx]      <= '0;
                        pressed_q[key_idx] <= ~cur;
                    end else begin
                        dcnt[key_idx] <= cnt_inc;
                    end
                    if (row == CW'(N-1)) state <= ST_ADVANCE;
                    else                 row   <= row + 1'b1;
                end
                ST_ADVANCE: begin
                    col    <= (col == CW'(N-1)) ? '0 : col + 1'b1;
                    cols_q <= {cols_q[N-2:0], cols_q[N-1]};
                    state  <= ST_SETTLE;
                end
                default: state <= ST_SETTLE;
            endcase
        end
    end

    // Press-event queue; a pop frees the head slot in the same cycle as a push.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.event_ready;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop)    ovf_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= key_idx;
    end

    assign bus.scan_cols   = cols_q;
    assign bus.pressed     = pressed_q;
    assign bus.event_valid = !empty;
    assign bus.event_index = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_button_matrix_scanner.sv
// Directed bench for button_matrix_scanner (N=5, SETTLE_DIVIDER=2, DEBOUNCE_SCANS=2):
// 11 cycles per column, 55 per scan; key (c,r) is sampled at edge 55*s + 11*c + 6 + r.
module tb_button_matrix_scanner;
    localparam int N = 5;

    logic clk, rst;
    logic [N-1:0][N-1:0] keys;   // keys[row][col]
    int   ecount;
    int   nvec, nerr;
    int   evq[$];

    button_matrix_scanner_if #(.N(N)) bus();

    button_matrix_scanner #(
        .N(N), .SETTLE_DIVIDER(2), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a row reads high when a closed key sits on the driven column.
    always_comb begin
        bus.sense_rows = '0;
        for (int r = 0; r < N; r++) bus.sense_rows[r] = |(keys[r] & bus.scan_cols);
    end

    always @(negedge clk)
        if (!rst && bus.event_valid && bus.event_ready) evq.push_back(int'(bus.event_index));

    task automatic run_to(input int e);
        while (ecount < e) begin
            @(posedge clk);
            ecount++;
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.ena = 1'b1; bus.event_ready = 1'b1; keys = '0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (bus.scan_cols !== 5'b00001) begin nerr++; $display("FAIL reset_cols got %b want 00001", bus.scan_cols); end
        nvec++; if (bus.pressed !== 25'd0) begin nerr++; $display("FAIL reset_pressed got %h want 0", bus.pressed); end
        nvec++; if (bus.event_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", bus.event_valid); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        nvec++; if (bus.event_index !== 5'd0) begin nerr++; $display("FAIL reset_index got %0d want 0", bus.event_index); end
        rst = 1'b0;
        ecount = 0;
    endtask

    task automatic test_scan_timing;
        run_to(10);
        nvec++; if (bus.scan_cols !== 5'b00001) begin nerr++; $display("FAIL cols_e10 got %b want 00001", bus.scan_cols); end
        run_to(11);
        nvec++; if (bus.scan_cols !== 5'b00010) begin nerr++; $display("FAIL cols_e11 got %b want 00010", bus.scan_cols); end
        run_to(44);
        nvec++; if (bus.scan_cols !== 5'b10000) begin nerr++; $display("FAIL cols_e44 got %b want 10000", bus.scan_cols); end
        run_to(54);
        nvec++; if (bus.scan_cols !== 5'b10000) begin nerr++; $display("FAIL cols_e54 got %b want 10000", bus.scan_cols); end
        run_to(55);
        nvec++; if (bus.scan_cols !== 5'b00001) begin nerr++; $display("FAIL cols_wrap got %b want 00001", bus.scan_cols); end
    endtask

    task automatic test_press_release;
        run_to(110);
        keys[3][2] = 1'b1;
        run_to(195);
        nvec++; if (bus.pressed[17] !== 1'b0) begin nerr++; $display("FAIL press_early got %b want 0", bus.pressed[17]); end
        run_to(196);
        nvec++; if (bus.pressed[17] !== 1'b1) begin nerr++; $display("FAIL press_set got %b want 1", bus.pressed[17]); end
        nvec++; if (bus.event_valid !== 1'b1) begin nerr++; $display("FAIL press_valid got %b want 1", bus.event_valid); end
        nvec++; if (bus.event_index !== 5'd17) begin nerr++; $display("FAIL press_index got %0d want 17", bus.event_index); end
        run_to(275);
        keys[3][2] = 1'b0;
        run_to(360);
        nvec++; if (bus.pressed[17] !== 1'b1) begin nerr++; $display("FAIL release_early got %b want 1", bus.pressed[17]); end
        run_to(361);
        nvec++; if (bus.pressed[17] !== 1'b0) begin nerr++; $display("FAIL release_clr got %b want 0", bus.pressed[17]); end
        nvec++; if (evq.size() !== 1) begin nerr++; $display("FAIL press_evcount got %0d want 1", evq.size()); end
        else begin
            nvec++; if (evq[0] !== 17) begin nerr++; $display("FAIL press_ev0 got %0d want 17", evq[0]); end
        end
    endtask

    task automatic test_glitch;
        run_to(385);
        keys[1][1] = 1'b1;
        run_to(403);
        nvec++; if (bus.pressed[6] !== 1'b0) begin nerr++; $display("FAIL glitch_s1 got %b want 0", bus.pressed[6]); end
        keys[1][1] = 1'b0;
        run_to(458);
        nvec++; if (bus.pressed[6] !== 1'b0) begin nerr++; $display("FAIL glitch_s2 got %b want 0", bus.pressed[6]); end
        keys[1][1] = 1'b1;
        // A second lone sample only debounces off a cleared count.
        run_to(513);
        nvec++; if (bus.pressed[6] !== 1'b0) begin nerr++; $display("FAIL glitch_cntclr got %b want 0", bus.pressed[6]); end
        keys[1][1] = 1'b0;
        run_to(568);
        nvec++; if (bus.pressed[6] !== 1'b0) begin nerr++; $display("FAIL glitch_s4 got %b want 0", bus.pressed[6]); end
        nvec++; if (evq.size() !== 1) begin nerr++; $display("FAIL glitch_evcount got %0d want 1", evq.size()); end
    endtask

    task automatic test_two_keys;
        run_to(605);
        keys[0][2] = 1'b1; keys[4][2] = 1'b1;
        run_to(688);
        nvec++; if (bus.pressed[2] !== 1'b1) begin nerr++; $display("FAIL two_p2 got %b want 1", bus.pressed[2]); end
        nvec++; if (bus.event_index !== 5'd2) begin nerr++; $display("FAIL two_idx2 got %0d want 2", bus.event_index); end
        run_to(692);
        nvec++; if (bus.pressed[22] !== 1'b1) begin nerr++; $display("FAIL two_p22 got %b want 1", bus.pressed[22]); end
        keys = '0;
        run_to(700);
        nvec++; if (evq.size() !== 3) begin nerr++; $display("FAIL two_evcount got %0d want 3", evq.size()); end
        else begin
            nvec++; if (evq[1] !== 2) begin nerr++; $display("FAIL two_ev1 got %0d want 2", evq[1]); end
            nvec++; if (evq[2] !== 22) begin nerr++; $display("FAIL two_ev2 got %0d want 22", evq[2]); end
        end
        run_to(880);
        nvec++; if (bus.pressed !== 25'd0) begin nerr++; $display("FAIL two_released got %h want 0", bus.pressed); end
    endtask

    task automatic test_overflow;
        int exp_ev [4] = '{3, 8, 13, 18};
        bus.event_ready = 1'b0;
        for (int r = 0; r < N; r++) keys[r][3] = 1'b1;
        run_to(977);
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
        nvec++; if (bus.event_index !== 5'd3) begin nerr++; $display("FAIL ovf_head got %0d want 3", bus.event_index); end
        run_to(978);
        nvec++; if (bus.overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        nvec++; if ((bus.pressed & 25'h0842108) !== 25'h0842108)
            begin nerr++; $display("FAIL ovf_pressed got %h want mask 0842108", bus.pressed); end
        bus.event_ready = 1'b1;
        run_to(990);
        nvec++; if (bus.event_valid !== 1'b0) begin nerr++; $display("FAIL ovf_drained got %b want 0", bus.event_valid); end
        nvec++; if (evq.size() !== 7) begin nerr++; $display("FAIL ovf_evcount got %0d want 7", evq.size()); end
        else for (int i = 0; i < 4; i++) begin
            nvec++; if (evq[3+i] !== exp_ev[i]) begin nerr++; $display("FAIL ovf_order[%0d] got %0d want %0d", i, evq[3+i], exp_ev[i]); end
        end
        keys = '0;
        run_to(1100);
        nvec++; if (bus.pressed !== 25'd0) begin nerr++; $display("FAIL ovf_released got %h want 0", bus.pressed); end
        nvec++; if (bus.overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    endtask

    task automatic test_freeze_and_reset;
        run_to(1102);
        bus.ena = 1'b0;
        run_to(1122);
        nvec++; if (bus.scan_cols !== 5'b00001) begin nerr++; $display("FAIL frz_cols got %b want 00001", bus.scan_cols); end
        bus.ena = 1'b1;
        run_to(1130);
        nvec++; if (bus.scan_cols !== 5'b00001) begin nerr++; $display("FAIL frz_resume_early got %b want 00001", bus.scan_cols); end
        run_to(1131);
        nvec++; if (bus.scan_cols !== 5'b00010) begin nerr++; $display("FAIL frz_resume got %b want 00010", bus.scan_cols); end
        bus.event_ready = 1'b0;
        keys[0][0] = 1'b1; keys[1][0] = 1'b1;
        run_to(1236);
        nvec++; if (bus.event_valid !== 1'b1) begin nerr++; $display("FAIL rst_q1 got %b want 1", bus.event_valid); end
        run_to(1237);
        nvec++; if (bus.pressed[5] !== 1'b1) begin nerr++; $display("FAIL rst_p5 got %b want 1", bus.pressed[5]); end
        rst = 1'b1; keys = '0;
        run_to(1238);
        nvec++; if (bus.scan_cols !== 5'b00001) begin nerr++; $display("FAIL rst_cols got %b want 00001", bus.scan_cols); end
        nvec++; if (bus.event_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", bus.event_valid); end
        nvec++; if (bus.pressed !== 25'd0) begin nerr++; $display("FAIL rst_pressed got %h want 0", bus.pressed); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b want 0", bus.overflow); end
        nvec++; if (bus.event_index !== 5'd0) begin nerr++; $display("FAIL rst_index got %0d want 0", bus.event_index); end
        rst = 1'b0;
    endtask

    initial begin
        nvec = 0; nerr = 0; ecount = 0;
        rst = 1'b1; keys = '0; bus.ena = 1'b0; bus.event_ready = 1'b0;
        test_reset;
        test_scan_timing;
        test_press_release;
        test_glitch;
        test_two_keys;
        test_overflow;
        test_freeze_and_reset;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
